// File: rtl/micro_sequencer_pkg.sv
// Shared types for the microprogram sequencer: next-address ops,
// fault causes and datapath widths.
package cpu_seq_pkg;

    localparam int UPC_W = 8;
    localparam int OPC_W = 6;

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'd0,
        SEQ_JUMP = 3'd1,
        SEQ_CJMP = 3'd2,
        SEQ_MAP  = 3'd3,
        SEQ_CALL = 3'd4,
        SEQ_RET  = 3'd5,
        SEQ_HOLD = 3'd6
    } seq_op_e;

    typedef enum logic [1:0] {
        FC_OVERFLOW  = 2'd0,
        FC_UNDERFLOW = 2'd1,
        FC_MAP_ERR   = 2'd2,
        FC_ILLEGAL   = 2'd3
    } fault_code_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// Microword, ROM and status bundle between the sequencer and
// the control store / datapath.
interface micro_sequencer_if #(
    parameter int STACK_DEPTH = 4
);
    import cpu_seq_pkg::*;

    localparam int SD_W = $clog2(STACK_DEPTH + 1);

    logic [OPC_W-1:0] ir_opcode;
    logic [OPC_W-1:0] map_addr;
    logic [UPC_W-1:0] map_data;
    logic             map_error;
    logic [UPC_W-1:0] mp_addr;
    logic [2:0]       seq_op;
    logic [UPC_W-1:0] br_addr;
    logic [1:0]       cond_sel;
    logic             cond_inv;
    logic [3:0]       flags;
    logic             stall;
    logic [SD_W-1:0]  stack_depth;
    logic             seq_fault;
    logic [1:0]       fault_code;

    modport master (
        input  ir_opcode, map_data, map_error, seq_op,
        input  br_addr, cond_sel, cond_inv, flags, stall,
        output map_addr, mp_addr, stack_depth,
        output seq_fault, fault_code
    );

    modport slave (
        output ir_opcode, map_data, map_error, seq_op,
        output br_addr, cond_sel, cond_inv, flags, stall,
        input  map_addr, mp_addr, stack_depth,
        input  seq_fault, fault_code
    );

endinterface

// File: rtl/micro_sequencer_stack.sv
// Micro-subroutine return LIFO; top of stack is read combinationally
// so RET can load it in the same cycle.
module useq_stack
    import cpu_seq_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    localparam int DW = $clog2(STACK_DEPTH + 1),
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [UPC_W-1:0] din,
    output logic [UPC_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [DW-1:0]    depth
);

    logic [UPC_W-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]    cnt;
    logic [DW-1:0]    cnt_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign cnt_m1 = cnt - DW'(1);
    assign wr_idx = AW'(cnt);
    assign rd_idx = AW'(cnt_m1);

    assign full  = (cnt == DW'(STACK_DEPTH));
    assign empty = (cnt == '0);
    assign depth = cnt;
    assign dout  = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            cnt         <= cnt + DW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt_m1;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register and next-address selection for the microprogrammed
// CPU, with call/return LIFO and sticky fault capture.
module micro_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int               STACK_DEPTH = 4,
    parameter logic [UPC_W-1:0] RESET_ADDR  = 8'h00,
    parameter logic [UPC_W-1:0] FAULT_ADDR  = 8'hFF
) (
    input  logic               clock,
    input  logic               reset,
    micro_sequencer_if.master  bus
);

    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [UPC_W-1:0] upc;
    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] upc_nxt;
    logic [UPC_W-1:0] stk_dout;
    logic             stk_full;
    logic             stk_empty;
    logic [DW-1:0]    stk_depth;
    logic             push;
    logic             pop;
    logic             fault;
    logic             cond;
    logic             seq_fault_q;
    fault_code_e      code_q;
    fault_code_e      code_nxt;
    seq_op_e          op;

    assign op       = seq_op_e'(bus.seq_op);
    assign upc_inc  = upc + UPC_W'(1);
    assign cond     = bus.flags[bus.cond_sel] ^ bus.cond_inv;

    always_comb begin
        upc_nxt  = upc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        fault    = 1'b0;
        code_nxt = FC_OVERFLOW;
        unique case (op)
            SEQ_NEXT: upc_nxt = upc_inc;
            SEQ_JUMP: upc_nxt = bus.br_addr;
            SEQ_CJMP: if (cond) upc_nxt = bus.br_addr;
            SEQ_MAP: begin
                if (bus.map_error) begin
                    fault    = 1'b1;
                    code_nxt = FC_MAP_ERR;
                end else begin
                    upc_nxt = bus.map_data;
                end
            end
            SEQ_CALL: begin
                if (stk_full) begin
                    fault    = 1'b1;
                    code_nxt = FC_OVERFLOW;
                end else begin
                    push    = 1'b1;
                    upc_nxt = bus.br_addr;
                end
            end
            SEQ_RET: begin
                if (stk_empty) begin
                    fault    = 1'b1;
                    code_nxt = FC_UNDERFLOW;
                end else begin
                    pop     = 1'b1;
                    upc_nxt = stk_dout;
                end
            end
            SEQ_HOLD: upc_nxt = upc;
            default: begin
                fault    = 1'b1;
                code_nxt = FC_ILLEGAL;
            end
        endcase
        if (fault) upc_nxt = FAULT_ADDR;
    end

    // Stall freezes the stack too, so gate the strobes here.
    useq_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push && !bus.stall),
        .pop   (pop && !bus.stall),
        .din   (upc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .depth (stk_depth)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            upc         <= RESET_ADDR;
            seq_fault_q <= 1'b0;
            code_q      <= FC_OVERFLOW;
        end else if (!bus.stall) begin
            upc <= upc_nxt;
            if (fault) begin
                seq_fault_q <= 1'b1;
                if (!seq_fault_q) code_q <= code_nxt;
            end
        end
    end

    assign bus.map_addr    = bus.ir_opcode;
    assign bus.mp_addr     = upc;
    assign bus.stack_depth = stk_depth;
    assign bus.seq_fault   = seq_fault_q;
    assign bus.fault_code  = code_q;

endmodule
